dcache_req_arbiter: RTL and testbench

DCACHE_REQ_ARBITER -- requirements
Module: dcache_req_arbiter

---
 rtl/dcache_req_arbiter_pkg.sv | 39 +++
 rtl/dcache_req_arbiter_if.sv | 25 ++
 rtl/dcache_req_arbiter_tag_fifo.sv | 55 +++++
 rtl/dcache_req_arbiter.sv | 147 ++++++++++++++
 tb/tb_dcache_req_arbiter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_req_arbiter_pkg.sv
// Shared encodings for the data-cache request arbiter: access sizes,
// slot tags and the request bundle forwarded to the cache.
package dcache_req_arbiter_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } size_e;

   typedef enum logic {
      SLOT_01 = 1'b0,
      SLOT_02 = 1'b1
   } slot_e;

   typedef struct packed {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } req_t;

   // Bundle one slot's request fields for forwarding to the cache.
   function automatic req_t pack_req(input logic        wr,
                                     input logic [1:0]  size,
                                     input logic [31:0] addr,
                                     input logic [3:0]  wstrb,
                                     input logic [31:0] wdata);
      req_t r;
      r.wr    = wr;
      r.size  = size;
      r.addr  = addr;
      r.wstrb = wstrb;
      r.wdata = wdata;
      return r;
   endfunction

endpackage

// File: rtl/dcache_req_arbiter_if.sv
// Cache-side request/response bus between the arbiter (master) and the
// data cache (slave).
interface dcache_req_arbiter_if;

   logic        c_req;
   logic        c_wr;
   logic [1:0]  c_size;
   logic [31:0] c_addr;
   logic [3:0]  c_wstrb;
   logic [31:0] c_wdata;
   logic        c_addr_ok;
   logic        c_data_ok;
   logic [31:0] c_rdata;

   modport master (
      output c_req, c_wr, c_size, c_addr, c_wstrb, c_wdata,
      input  c_addr_ok, c_data_ok, c_rdata
   );

   modport slave (
      input  c_req, c_wr, c_size, c_addr, c_wstrb, c_wdata,
      output c_addr_ok, c_data_ok, c_rdata
   );

endinterface

// File: rtl/dcache_req_arbiter_tag_fifo.sv
// In-order FIFO of 1-bit slot tags, one entry per accepted cache request.
// Push and pop in the same cycle advance both pointers and leave the count
// unchanged, including when the FIFO is empty (the pushed tag is consumed
// by the caller directly).
module tag_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     din,
   output logic                     dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int              PW         = $clog2(DEPTH);
   localparam logic [PW:0]     FULL_COUNT = (PW + 1)'(DEPTH);

   logic [DEPTH-1:0] mem_r;
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [PW:0]      count_r;

   // Tag storage, wrapping pointers and occupancy count.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mem_r    <= '0;
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push) begin
            mem_r[wr_ptr_r] <= din;
            wr_ptr_r        <= wr_ptr_r + 1'b1;
         end
         if (pop) begin
            rd_ptr_r <= rd_ptr_r + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_r <= count_r + 1'b1;
            2'b01:   count_r <= count_r - 1'b1;
            default: count_r <= count_r;
         endcase
      end
   end

   assign dout  = mem_r[rd_ptr_r];
   assign full  = (count_r == FULL_COUNT);
   assign empty = (count_r == '0);
   assign count = count_r;

endmodule

// File: rtl/dcache_req_arbiter.sv
// Two-slot data-cache request arbiter. Slot 01 has fixed priority so a
// dual-issue pair reaches the cache in program order. Requests and
// responses pass through combinationally; a tag FIFO routes each in-order
// response back to the slot that issued it.
module dcache_req_arbiter
   import dcache_req_arbiter_pkg::*;
#(
   parameter int OUTSTANDING = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_01,
   input  logic        wr_01,
   input  logic [1:0]  size_01,
   input  logic [31:0] addr_01,
   input  logic [3:0]  wstrb_01,
   input  logic [31:0] wdata_01,
   input  logic        req_02,
   input  logic        wr_02,
   input  logic [1:0]  size_02,
   input  logic [31:0] addr_02,
   input  logic [3:0]  wstrb_02,
   input  logic [31:0] wdata_02,
   output logic        addr_ok_01,
   output logic        data_ok_01,
   output logic [31:0] rdata_01,
   output logic        addr_ok_02,
   output logic        data_ok_02,
   output logic [31:0] rdata_02,
   output logic        busy,
   output logic        resp_err,
   dcache_req_arbiter_if.master cache
);

   localparam int             CW        = $clog2(OUTSTANDING) + 1;
   localparam logic [CW-1:0]  ONE_COUNT = CW'(1);

   req_t          sel_req_s;
   slot_e         sel_slot_s;
   logic          any_req_s;
   logic          grant_valid_s;
   logic          accept_s;
   logic          pop_s;
   logic          head_tag_s;
   logic          fifo_tag_s;
   logic          full_s;
   logic          empty_s;
   logic [CW-1:0] fifo_count_s;
   logic          busy_next_s;
   logic          err_hit_s;
   logic          busy_r;
   logic          resp_err_r;

   // Pick the request to forward: slot 01 always wins, slot 02 only when 01 is idle.
   always_comb begin
      sel_req_s  = '0;
      sel_slot_s = SLOT_01;
      any_req_s  = 1'b0;
      if (!resetn) begin
         sel_req_s  = '0;
         sel_slot_s = SLOT_01;
         any_req_s  = 1'b0;
      end else if (req_01) begin
         sel_req_s  = pack_req(wr_01, size_01, addr_01, wstrb_01, wdata_01);
         sel_slot_s = SLOT_01;
         any_req_s  = 1'b1;
      end else if (req_02) begin
         sel_req_s  = pack_req(wr_02, size_02, addr_02, wstrb_02, wdata_02);
         sel_slot_s = SLOT_02;
         any_req_s  = 1'b1;
      end else begin
         sel_req_s  = '0;
         sel_slot_s = SLOT_01;
         any_req_s  = 1'b0;
      end
   end

   // No new request may be offered while every FIFO entry is in flight.
   assign grant_valid_s = any_req_s & ~full_s;
   assign accept_s      = grant_valid_s & cache.c_addr_ok;

   assign cache.c_req   = grant_valid_s;
   assign cache.c_wr    = sel_req_s.wr;
   assign cache.c_size  = sel_req_s.size;
   assign cache.c_addr  = sel_req_s.addr;
   assign cache.c_wstrb = sel_req_s.wstrb;
   assign cache.c_wdata = sel_req_s.wdata;

   // Route a cache response to its slot; an empty FIFO forwards the tag being accepted this cycle.
   always_comb begin
      pop_s      = cache.c_data_ok & resetn & (~empty_s | accept_s);
      head_tag_s = empty_s ? sel_slot_s : fifo_tag_s;
      err_hit_s  = cache.c_data_ok & empty_s & ~accept_s;
      data_ok_01 = pop_s & (head_tag_s == SLOT_01);
      data_ok_02 = pop_s & (head_tag_s == SLOT_02);
      addr_ok_01 = accept_s & (sel_slot_s == SLOT_01);
      addr_ok_02 = accept_s & (sel_slot_s == SLOT_02);
      if (data_ok_01) begin
         rdata_01 = cache.c_rdata;
      end else begin
         rdata_01 = 32'd0;
      end
      if (data_ok_02) begin
         rdata_02 = cache.c_rdata;
      end else begin
         rdata_02 = 32'd0;
      end
   end

   tag_fifo #(
      .DEPTH (OUTSTANDING)
   ) u_tag_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (accept_s),
      .pop    (pop_s),
      .din    (sel_slot_s),
      .dout   (fifo_tag_s),
      .full   (full_s),
      .empty  (empty_s),
      .count  (fifo_count_s)
   );

   // Predict occupancy after this edge so busy tracks the count without lag.
   always_comb begin
      case ({accept_s, pop_s})
         2'b10:   busy_next_s = 1'b1;
         2'b01:   busy_next_s = (fifo_count_s != ONE_COUNT);
         default: busy_next_s = (fifo_count_s != '0);
      endcase
   end

   // Registered status: busy flag and sticky unexpected-response error.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         busy_r     <= 1'b0;
         resp_err_r <= 1'b0;
      end else begin
         busy_r     <= busy_next_s;
         resp_err_r <= resp_err_r | err_hit_s;
      end
   end

   assign busy     = busy_r;
   assign resp_err = resp_err_r;

endmodule

// File: tb/tb_dcache_req_arbiter.sv
// Bench for dcache_req_arbiter: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a queue model.
module tb_dcache_req_arbiter;
   import dcache_req_arbiter_pkg::*;

   localparam int OUT = 4;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        req_01, wr_01, req_02, wr_02;
   logic [1:0]  size_01, size_02;
   logic [31:0] addr_01, addr_02, wdata_01, wdata_02;
   logic [3:0]  wstrb_01, wstrb_02;
   logic        addr_ok_01, data_ok_01, addr_ok_02, data_ok_02;
   logic [31:0] rdata_01, rdata_02;
   logic        busy, resp_err;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dcache_req_arbiter_if cif();

   dcache_req_arbiter #(.OUTSTANDING(OUT)) dut (
      .clk(clk), .resetn(resetn),
      .req_01(req_01), .wr_01(wr_01), .size_01(size_01), .addr_01(addr_01),
      .wstrb_01(wstrb_01), .wdata_01(wdata_01),
      .req_02(req_02), .wr_02(wr_02), .size_02(size_02), .addr_02(addr_02),
      .wstrb_02(wstrb_02), .wdata_02(wdata_02),
      .addr_ok_01(addr_ok_01), .data_ok_01(data_ok_01), .rdata_01(rdata_01),
      .addr_ok_02(addr_ok_02), .data_ok_02(data_ok_02), .rdata_02(rdata_02),
      .busy(busy), .resp_err(resp_err),
      .cache(cif.master)
   );

   typedef struct {
      logic        r1, r2, w2;
      logic [31:0] a1, a2;
      logic        aok, dok;
      logic [31:0] rd;
      logic        e_creq;
      logic [31:0] e_addr;
      logic        e_wr, e_ao1, e_ao2, e_do1, e_do2;
      logic [31:0] e_rd1, e_rd2;
      logic        e_busy;
   } vec_t;

   vec_t vt[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      req_01 = 1'b0; wr_01 = 1'b0; size_01 = SIZE_WORD; addr_01 = 32'h0;
      wstrb_01 = 4'h0; wdata_01 = 32'h0;
      req_02 = 1'b0; wr_02 = 1'b0; size_02 = SIZE_WORD; addr_02 = 32'h0;
      wstrb_02 = 4'h0; wdata_02 = 32'h0;
      cif.c_addr_ok = 1'b0; cif.c_data_ok = 1'b0; cif.c_rdata = 32'h0;
   endtask

   // One cycle with only a response from the cache; checks which slot gets it.
   task automatic resp_cycle(input string name, input logic [31:0] rd, input logic exp_slot);
      @(negedge clk);
      idle_inputs();
      cif.c_data_ok = 1'b1; cif.c_rdata = rd;
      #1;
      chk({name, "_dok01"}, data_ok_01, exp_slot == 1'b0);
      chk({name, "_dok02"}, data_ok_02, exp_slot == 1'b1);
      chk({name, "_rdata"}, exp_slot ? rdata_02 : rdata_01, rd);
   endtask

   logic        q[$];
   bit          m_err;
   logic        m_full, m_any, m_gslot, m_creq, m_acc, m_pop, m_head, m_errnew;
   logic [31:0] m_addr;

   initial begin
      idle_inputs();
      resetn = 1'b0;
      // Reset holds outputs low even with a live request.
      @(negedge clk);
      req_01 = 1'b1; addr_01 = 32'h40; cif.c_addr_ok = 1'b1; cif.c_data_ok = 1'b1;
      #1;
      chk("rst_c_req", cif.c_req, 1'b0);
      chk("rst_addr_ok_01", addr_ok_01, 1'b0);
      chk("rst_data_ok_01", data_ok_01, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_resp_err", resp_err, 1'b0);
      @(negedge clk);
      idle_inputs();
      resetn = 1'b1;

      // Directed vectors: ordered dual load, slot-02 store, empty bypass.
      vt[0] = '{1'b1, 1'b1, 1'b0, 32'h100, 32'h104, 1'b1, 1'b0, 32'h0,
                1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
      vt[1] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h104, 1'b1, 1'b0, 32'h0,
                1'b1, 32'h104, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1};
      vt[2] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hAAAA,
                1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hAAAA, 32'h0, 1'b1};
      vt[3] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hBBBB,
                1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'hBBBB, 1'b1};
      vt[4] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
      vt[5] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h200, 1'b1, 1'b0, 32'h0,
                1'b1, 32'h200, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
      vt[6] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h5555,
                1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h5555, 1'b1};
      vt[7] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
      vt[8] = '{1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 1'b1, 1'b1, 32'h1234,
                1'b1, 32'h300, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1234, 32'h0, 1'b0};
      vt[9] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         idle_inputs();
         req_01 = vt[i].r1; addr_01 = vt[i].a1;
         req_02 = vt[i].r2; addr_02 = vt[i].a2; wr_02 = vt[i].w2;
         wstrb_02 = vt[i].w2 ? 4'hF : 4'h0;
         cif.c_addr_ok = vt[i].aok; cif.c_data_ok = vt[i].dok; cif.c_rdata = vt[i].rd;
         #1;
         chk($sformatf("vec%0d_c_req", i), cif.c_req, vt[i].e_creq);
         chk($sformatf("vec%0d_c_addr", i), cif.c_addr, vt[i].e_addr);
         chk($sformatf("vec%0d_c_wr", i), cif.c_wr, vt[i].e_wr);
         chk($sformatf("vec%0d_addr_ok_01", i), addr_ok_01, vt[i].e_ao1);
         chk($sformatf("vec%0d_addr_ok_02", i), addr_ok_02, vt[i].e_ao2);
         chk($sformatf("vec%0d_data_ok_01", i), data_ok_01, vt[i].e_do1);
         chk($sformatf("vec%0d_data_ok_02", i), data_ok_02, vt[i].e_do2);
         chk($sformatf("vec%0d_rdata_01", i), rdata_01, vt[i].e_rd1);
         chk($sformatf("vec%0d_rdata_02", i), rdata_02, vt[i].e_rd2);
         chk($sformatf("vec%0d_busy", i), busy, vt[i].e_busy);
         if (vt[i].w2) chk($sformatf("vec%0d_c_wstrb", i), cif.c_wstrb, 32'hF);
      end
      chk("vec_resp_err_clear", resp_err, 1'b0);

      // Fill to the limit with alternating slots: 01,02,01,02.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         idle_inputs();
         req_01 = (i % 2 == 0); req_02 = (i % 2 == 1);
         addr_01 = 32'h400 + 32'(i * 4); addr_02 = 32'h400 + 32'(i * 4);
         cif.c_addr_ok = 1'b1;
         #1;
         chk($sformatf("fill%0d_c_req", i), cif.c_req, 1'b1);
         chk($sformatf("fill%0d_addr_ok", i), (i % 2 == 0) ? addr_ok_01 : addr_ok_02, 1'b1);
      end
      // Fifth request stalls while full.
      @(negedge clk);
      idle_inputs();
      req_02 = 1'b1; addr_02 = 32'h500; cif.c_addr_ok = 1'b1;
      #1;
      chk("full_c_req", cif.c_req, 1'b0);
      chk("full_addr_ok_02", addr_ok_02, 1'b0);
      chk("full_busy", busy, 1'b1);
      // Response while full: head is slot 01, request still blocked this cycle.
      @(negedge clk);
      cif.c_data_ok = 1'b1; cif.c_rdata = 32'h1111;
      #1;
      chk("full_pop_c_req", cif.c_req, 1'b0);
      chk("full_pop_data_ok_01", data_ok_01, 1'b1);
      chk("full_pop_rdata_01", rdata_01, 32'h1111);
      chk("full_pop_data_ok_02", data_ok_02, 1'b0);
      // Fifth request accepted the cycle after, writing the wrapped slot.
      @(negedge clk);
      cif.c_data_ok = 1'b0;
      #1;
      chk("wrap_c_req", cif.c_req, 1'b1);
      chk("wrap_c_addr", cif.c_addr, 32'h500);
      chk("wrap_addr_ok_02", addr_ok_02, 1'b1);
      resp_cycle("drain0", 32'h2222, 1'b1);
      resp_cycle("drain1", 32'h3333, 1'b0);
      resp_cycle("drain2", 32'h4444, 1'b1);
      resp_cycle("drain3", 32'h5555, 1'b1);
      @(negedge clk);
      idle_inputs();
      #1;
      chk("drain_busy", busy, 1'b0);
      chk("drain_resp_err", resp_err, 1'b0);

      // Response with nothing outstanding: no data_ok, sticky error.
      @(negedge clk);
      cif.c_data_ok = 1'b1; cif.c_rdata = 32'hDEAD;
      #1;
      chk("orphan_data_ok_01", data_ok_01, 1'b0);
      chk("orphan_data_ok_02", data_ok_02, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         idle_inputs();
         req_01 = 1'b1; addr_01 = 32'h600 + 32'(i * 4); cif.c_addr_ok = 1'b1;
         #1;
         chk($sformatf("err_sticky%0d", i), resp_err, 1'b1);
      end
      @(negedge clk);
      idle_inputs();
      #1;
      chk("three_busy", busy, 1'b1);
      // Reset in mid-operation with three entries outstanding.
      @(negedge clk);
      resetn = 1'b0;
      req_01 = 1'b1; cif.c_addr_ok = 1'b1; cif.c_data_ok = 1'b1;
      #1;
      chk("midrst_c_req", cif.c_req, 1'b0);
      chk("midrst_addr_ok_01", addr_ok_01, 1'b0);
      chk("midrst_data_ok_01", data_ok_01, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_resp_err", resp_err, 1'b0);
      @(negedge clk);
      idle_inputs();
      resetn = 1'b1;
      #1;
      chk("postrst_busy", busy, 1'b0);
      chk("postrst_resp_err", resp_err, 1'b0);

      // Randomized traffic against a tag-queue model.
      q.delete();
      m_err = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         resetn = ($urandom_range(0, 99) != 0);
         req_01 = ($urandom_range(0, 2) == 0); req_02 = ($urandom_range(0, 1) == 1);
         wr_01 = 1'($urandom); wr_02 = 1'($urandom);
         size_01 = 2'($urandom_range(0, 2)); size_02 = 2'($urandom_range(0, 2));
         addr_01 = $urandom; addr_02 = $urandom;
         wstrb_01 = 4'($urandom); wstrb_02 = 4'($urandom);
         wdata_01 = $urandom; wdata_02 = $urandom;
         cif.c_addr_ok = ($urandom_range(0, 9) < 7);
         cif.c_data_ok = (q.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
         cif.c_rdata = $urandom;
         #1;
         if (!resetn) begin
            q.delete();
            m_err = 1'b0;
            chk("rnd_rst_c_req", cif.c_req, 1'b0);
            chk("rnd_rst_ok", {addr_ok_01, addr_ok_02, data_ok_01, data_ok_02}, 4'b0);
            chk("rnd_rst_status", {busy, resp_err}, 2'b0);
         end else begin
            m_full  = (q.size() == OUT);
            m_any   = req_01 | req_02;
            m_gslot = req_01 ? 1'b0 : 1'b1;
            m_creq  = m_any && !m_full;
            m_acc   = m_creq && cif.c_addr_ok;
            m_pop   = 1'b0; m_head = 1'b0; m_errnew = 1'b0;
            if (cif.c_data_ok) begin
               if (q.size() > 0) begin m_pop = 1'b1; m_head = q[0]; end
               else if (m_acc) begin m_pop = 1'b1; m_head = m_gslot; end
               else m_errnew = 1'b1;
            end
            chk("rnd_c_req", cif.c_req, m_creq);
            chk("rnd_addr_ok_01", addr_ok_01, m_acc && m_gslot == 1'b0);
            chk("rnd_addr_ok_02", addr_ok_02, m_acc && m_gslot == 1'b1);
            chk("rnd_data_ok_01", data_ok_01, m_pop && m_head == 1'b0);
            chk("rnd_data_ok_02", data_ok_02, m_pop && m_head == 1'b1);
            chk("rnd_rdata_01", rdata_01, (m_pop && m_head == 1'b0) ? cif.c_rdata : 32'h0);
            chk("rnd_rdata_02", rdata_02, (m_pop && m_head == 1'b1) ? cif.c_rdata : 32'h0);
            chk("rnd_busy", busy, q.size() != 0);
            chk("rnd_resp_err", resp_err, m_err);
            if (m_any) begin
               m_addr = m_gslot ? addr_02 : addr_01;
               chk("rnd_c_addr", cif.c_addr, m_addr);
               chk("rnd_c_wr", cif.c_wr, m_gslot ? wr_02 : wr_01);
               chk("rnd_c_size", cif.c_size, m_gslot ? size_02 : size_01);
               chk("rnd_c_wstrb", cif.c_wstrb, m_gslot ? wstrb_02 : wstrb_01);
               chk("rnd_c_wdata", cif.c_wdata, m_gslot ? wdata_02 : wdata_01);
            end
            if (m_acc) q.push_back(m_gslot);
            if (m_pop) void'(q.pop_front());
            if (m_errnew) m_err = 1'b1;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
